// File: rtl/kws_pkg.sv
// Shared types and constants for the KWS PSRAM access path: arbiter FSM states,
// idle pin levels and the engine-to-requester index mapping.
package kws_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Pin levels presented to the pad whenever nobody owns the bus
    localparam logic       PSRAM_SCK_IDLE    = 1'b0;
    localparam logic       PSRAM_CE_N_IDLE   = 1'b1;
    localparam logic [3:0] PSRAM_DOUT_IDLE   = 4'h0;
    localparam logic [3:0] PSRAM_DOUTEN_IDLE = 4'h0;

    localparam int REQ_CONV1   = 0;
    localparam int REQ_CONV2   = 1;
    localparam int REQ_FC1     = 2;
    localparam int REQ_FC2     = 3;
    localparam int REQ_MAXPOOL = 4;
    localparam int REQ_SOFTMAX = 5;
    localparam int REQ_COUNT   = 6;

    // Bits needed to index n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psram_arbiter_rr.sv
// Round-robin pick: first set bit of req_i at or after ptr_i, wrapping at NUM_REQ.
// Purely combinational; returns both the one-hot winner and its encoded id.
module rr_arbiter
    import kws_pkg::*;
#(
    parameter int NUM_REQ = REQ_COUNT,
    parameter int IDW     = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic               valid_o,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDW-1:0]     id_o
);

    localparam int SW = IDW + 1;

    logic [SW-1:0]  sum;
    logic [IDW-1:0] pos;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        valid_o  = 1'b0;
        onehot_o = '0;
        id_o     = '0;
        sum      = '0;
        pos      = '0;
        // Scan from the farthest offset down so the nearest requester is written last and wins
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_i} + SW'(off);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            pos = sum[IDW-1:0];
            if (req_i[pos]) begin
                valid_o       = 1'b1;
                onehot_o      = '0;
                onehot_o[pos] = 1'b1;
                id_o          = pos;
            end
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Single-owner arbiter for the shared QSPI PSRAM: round-robin grant with ownership lock,
// enforced CE# high time between owners and a maximum-ownership watchdog.
module psram_arbiter
    import kws_pkg::*;
#(
    parameter int NUM_REQ     = REQ_COUNT,
    parameter int CE_HIGH_CYC = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int IDW         = idx_width(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     gnt,
    input  logic [NUM_REQ-1:0]     req_sck,
    input  logic [NUM_REQ-1:0]     req_ce_n,
    input  logic [4*NUM_REQ-1:0]   req_dout,
    input  logic [4*NUM_REQ-1:0]   req_douten,
    output logic [3:0]             req_din,
    output logic                   psram_sck,
    output logic                   psram_ce_n,
    output logic [3:0]             psram_dout,
    output logic [3:0]             psram_douten,
    input  logic [3:0]             psram_din,
    output logic                   busy,
    output logic [IDW-1:0]         owner_id,
    output logic                   timeout_err,
    output logic [IDW-1:0]         timeout_id
);

    localparam int WDW = idx_width(TIMEOUT_CYC);
    localparam int CEW = idx_width(CE_HIGH_CYC);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
    localparam logic [CEW-1:0] CE_LAST = CEW'(CE_HIGH_CYC - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     tid_q, tid_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic [CEW-1:0]     ce_q, ce_d;
    logic               err_q, err_d;
    logic               release_bus;

    logic               pick_valid;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDW-1:0]     pick_id;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req_i    (req & ~mask_q),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .onehot_o (pick_onehot),
        .id_o     (pick_id)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        tid_d       = tid_q;
        wd_d        = wd_q;
        ce_d        = ce_q;
        err_d       = err_q;
        release_bus = 1'b0;
        // A masked (timed-out) requester becomes eligible again once it has dropped req
        mask_d      = mask_q & req;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_onehot;
                    owner_d = pick_id;
                    wd_d    = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                wd_d = wd_q + 1'b1;
                if (!req[owner_q]) begin
                    release_bus = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    release_bus     = 1'b1;
                    err_d           = 1'b1;
                    tid_d           = owner_q;
                    mask_d[owner_q] = 1'b1;
                end
            end
            RELEASE: begin
                ce_d = ce_q + 1'b1;
                if (ce_q == CE_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (release_bus) begin
            gnt_d   = '0;
            ptr_d   = next_id(owner_q);
            ce_d    = '0;
            state_d = RELEASE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            mask_q  <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            tid_q   <= '0;
            wd_q    <= '0;
            ce_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples the pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            tid_q   <= tid_d;
            wd_q    <= wd_d;
            ce_q    <= ce_d;
            err_q   <= err_d;
        end
    end

    // Pins follow the owner only while ACTIVE; owner_q is registered so the mux adds no latency
    always_comb begin
        psram_sck    = PSRAM_SCK_IDLE;
        psram_ce_n   = PSRAM_CE_N_IDLE;
        psram_dout   = PSRAM_DOUT_IDLE;
        psram_douten = PSRAM_DOUTEN_IDLE;
        if (state_q == ACTIVE) begin
            psram_sck    = req_sck[owner_q];
            psram_ce_n   = req_ce_n[owner_q];
            psram_dout   = req_dout[{owner_q, 2'b00} +: 4];
            psram_douten = req_douten[{owner_q, 2'b00} +: 4];
        end
    end

    assign req_din     = psram_din;
    assign gnt         = gnt_q;
    assign busy        = (state_q != IDLE);
    assign owner_id    = owner_q;
    assign timeout_err = err_q;
    assign timeout_id  = tid_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed and random bench for psram_arbiter: a grant scoreboard plus pin, release-gap,
// watchdog, reset and fairness checks.
module tb_psram_arbiter;
    import kws_pkg::*;

    localparam int NUM_REQ     = 6;
    localparam int CE_HIGH_CYC = 4;
    localparam int TIMEOUT_CYC = 4096;
    localparam int IDW         = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   req_sck;
    logic [NUM_REQ-1:0]   req_ce_n;
    logic [4*NUM_REQ-1:0] req_dout;
    logic [4*NUM_REQ-1:0] req_douten;
    logic [3:0]           req_din;
    logic                 psram_sck;
    logic                 psram_ce_n;
    logic [3:0]           psram_dout;
    logic [3:0]           psram_douten;
    logic [3:0]           psram_din;
    logic                 busy;
    logic [IDW-1:0]       owner_id;
    logic                 timeout_err;
    logic [IDW-1:0]       timeout_id;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];

    int id, cnt, n_grants, hi_run, g;
    logic seen_low;
    logic [NUM_REQ-1:0] prev_gnt;
    int hold [NUM_REQ];
    int waits[NUM_REQ];

    always #5 clk = ~clk;

    // Engines hold their chip enable high until they see their grant
    assign req_ce_n = ~gnt;

    psram_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .CE_HIGH_CYC (CE_HIGH_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .IDW         (IDW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .gnt          (gnt),
        .req_sck      (req_sck),
        .req_ce_n     (req_ce_n),
        .req_dout     (req_dout),
        .req_douten   (req_douten),
        .req_din      (req_din),
        .psram_sck    (psram_sck),
        .psram_ce_n   (psram_ce_n),
        .psram_dout   (psram_dout),
        .psram_douten (psram_douten),
        .psram_din    (psram_din),
        .busy         (busy),
        .owner_id     (owner_id),
        .timeout_err  (timeout_err),
        .timeout_id   (timeout_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int gnt_to_id(input logic [NUM_REQ-1:0] gv);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (gv[i]) r = i;
        return r;
    endfunction

    // owner < 0 means the pins must be at their idle levels
    task automatic check_pins(input string tag, input int owner);
        if (owner < 0) begin
            check({tag, "_ce_n"},   32'(psram_ce_n),   32'(PSRAM_CE_N_IDLE));
            check({tag, "_sck"},    32'(psram_sck),    32'(PSRAM_SCK_IDLE));
            check({tag, "_dout"},   32'(psram_dout),   32'(PSRAM_DOUT_IDLE));
            check({tag, "_douten"}, 32'(psram_douten), 32'(PSRAM_DOUTEN_IDLE));
        end else begin
            check({tag, "_ce_n"},   32'(psram_ce_n),   0);
            check({tag, "_sck"},    32'(psram_sck),    32'(owner % 2));
            check({tag, "_dout"},   32'(psram_dout),   32'(owner + 1));
            check({tag, "_douten"}, 32'(psram_douten), 32'(15 - owner));
        end
    endtask

    task automatic wait_grant(input string tag, input int exp_lat, output int gid);
        int lat;
        int exp_id;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (gnt === '0 && lat < 100);
        gid    = gnt_to_id(gnt);
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_lat"},   32'(lat),      32'(exp_lat));
        check({tag, "_id"},    32'(gid),      32'(exp_id));
        check({tag, "_gnt"},   32'(gnt),      32'(1) << exp_id);
        check({tag, "_owner"}, 32'(owner_id), 32'(exp_id));
        check({tag, "_busy"},  32'(busy),     1);
        check_pins({tag, "_pins"}, exp_id);
    endtask

    // Call at the negedge where the owner drops req; counts the busy cycles that follow
    task automatic wait_idle(input string tag, input int exp_cycles);
        int rel;
        rel = 0;
        @(negedge clk);
        while (busy === 1'b1 && rel < 100) begin
            rel++;
            if (rel == 1) begin
                check({tag, "_gnt_off"}, 32'(gnt), 0);
                check_pins({tag, "_idle"}, -1);
            end
            @(negedge clk);
        end
        check({tag, "_release"}, 32'(rel), 32'(exp_cycles));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed time %0t, required finish before it", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        psram_din = 4'h0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_sck[i]           = 1'(i % 2);
            req_dout[4*i +: 4]   = 4'(i + 1);
            req_douten[4*i +: 4] = 4'(15 - i);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_gnt",    32'(gnt),         0);
        check("rst_busy",   32'(busy),        0);
        check("rst_owner",  32'(owner_id),    0);
        check("rst_err",    32'(timeout_err), 0);
        check("rst_tid",    32'(timeout_id),  0);
        check_pins("rst_pins", -1);

        // Single requester on an idle bus
        exp_q.push_back(REQ_FC1);
        req[REQ_FC1] = 1'b1;
        wait_grant("single", 1, id);
        psram_din = 4'hA;
        #1;
        check("din_bcast_a", 32'(req_din), 32'hA);
        psram_din = 4'h5;
        #1;
        check("din_bcast_5", 32'(req_din), 32'h5);
        repeat (3) @(negedge clk);
        check_pins("single_hold", REQ_FC1);
        req[REQ_FC1] = 1'b0;
        wait_idle("single", CE_HIGH_CYC);

        // All engines requesting: strict rotation, fixed gap between owners
        do_reset();
        exp_q.push_back(REQ_CONV1);
        exp_q.push_back(REQ_CONV2);
        exp_q.push_back(REQ_FC1);
        exp_q.push_back(REQ_FC2);
        exp_q.push_back(REQ_MAXPOOL);
        exp_q.push_back(REQ_SOFTMAX);
        exp_q.push_back(REQ_CONV1);
        req = '1;
        for (int k = 0; k < 7; k++) begin
            wait_grant($sformatf("rr%0d", k), (k == 0) ? 1 : CE_HIGH_CYC + 2, id);
            if (k == 2) req[REQ_CONV1] = 1'b1;
            repeat (10) @(negedge clk);
            if (id >= 0) req[id] = 1'b0;
        end
        wait_idle("rr_end", CE_HIGH_CYC);

        // Late arrivals wait, then follow the pointer past the old owner
        do_reset();
        exp_q.push_back(REQ_CONV2);
        req[REQ_CONV2] = 1'b1;
        wait_grant("late_a", 1, id);
        repeat (3) @(negedge clk);
        req[REQ_MAXPOOL] = 1'b1;
        req[REQ_CONV1]   = 1'b1;
        exp_q.push_back(REQ_MAXPOOL);
        exp_q.push_back(REQ_CONV1);
        repeat (3) @(negedge clk);
        check("late_no_preempt", 32'(gnt), 32'(1) << REQ_CONV2);
        req[REQ_CONV2] = 1'b0;
        wait_grant("late_b", CE_HIGH_CYC + 2, id);
        repeat (2) @(negedge clk);
        req[REQ_MAXPOOL] = 1'b0;
        wait_grant("late_c", CE_HIGH_CYC + 2, id);
        repeat (2) @(negedge clk);
        req[REQ_CONV1] = 1'b0;
        wait_idle("late_end", CE_HIGH_CYC);

        // req dropped in the very cycle the watchdog expires: ordinary release
        do_reset();
        exp_q.push_back(REQ_FC1);
        req[REQ_FC1] = 1'b1;
        wait_grant("dropwd", 1, id);
        cnt = 1;
        while (cnt < TIMEOUT_CYC) begin
            @(negedge clk);
            cnt++;
        end
        check("dropwd_still_gnt", 32'(gnt), 32'(1) << REQ_FC1);
        req[REQ_FC1] = 1'b0;
        wait_idle("dropwd", CE_HIGH_CYC);
        check("dropwd_err", 32'(timeout_err), 0);
        exp_q.push_back(REQ_FC1);
        req[REQ_FC1] = 1'b1;
        wait_grant("dropwd_regrant", 1, id);
        req[REQ_FC1] = 1'b0;
        wait_idle("dropwd_rel", CE_HIGH_CYC);

        // Watchdog: owner that never drops req is forced off after TIMEOUT_CYC cycles
        exp_q.push_back(REQ_FC2);
        req[REQ_FC2] = 1'b1;
        wait_grant("wd", 1, id);
        cnt = 1;
        do begin
            @(negedge clk);
            if (gnt !== '0) cnt++;
        end while (gnt !== '0 && cnt < TIMEOUT_CYC + 100);
        check("wd_hold_cycles", 32'(cnt),         32'(TIMEOUT_CYC));
        check("wd_err",         32'(timeout_err), 1);
        check("wd_tid",         32'(timeout_id),  32'(REQ_FC2));
        check("wd_busy",        32'(busy),        1);
        check_pins("wd_idle", -1);
        n_grants = 0;
        repeat (20) begin
            @(negedge clk);
            if (gnt !== '0) n_grants++;
        end
        check("wd_masked", 32'(n_grants), 0);
        req[REQ_FC2] = 1'b0;
        @(negedge clk);
        exp_q.push_back(REQ_FC2);
        req[REQ_FC2] = 1'b1;
        wait_grant("wd_regrant", 1, id);
        check("wd_err_sticky", 32'(timeout_err), 1);
        check("wd_tid_sticky", 32'(timeout_id),  32'(REQ_FC2));
        req[REQ_FC2] = 1'b0;
        wait_idle("wd_rel", CE_HIGH_CYC);

        // Reset in the middle of an ACTIVE transaction
        exp_q.push_back(REQ_MAXPOOL);
        req[REQ_MAXPOOL] = 1'b1;
        wait_grant("rstmid_a", 1, id);
        repeat (2) @(negedge clk);
        req[REQ_CONV2] = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_gnt",   32'(gnt),         0);
        check("rstmid_busy",  32'(busy),        0);
        check("rstmid_err",   32'(timeout_err), 0);
        check("rstmid_owner", 32'(owner_id),    0);
        check_pins("rstmid", -1);
        rst = 1'b0;
        exp_q.push_back(REQ_CONV2);
        wait_grant("rstmid_b", 1, id);
        req = '0;
        wait_idle("rstmid_end", CE_HIGH_CYC);

        // Random traffic: one-hot grant, CE# gap between owners, bounded waiting
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            hold[i]  = 0;
            waits[i] = 0;
        end
        hi_run   = 0;
        seen_low = 1'b0;
        prev_gnt = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check("rnd_onehot", 32'($onehot0(gnt)), 1);
            if (psram_ce_n === 1'b1) begin
                hi_run++;
            end else begin
                if (seen_low && hi_run > 0) check("rnd_ce_gap", 32'(hi_run >= CE_HIGH_CYC), 1);
                seen_low = 1'b1;
                hi_run   = 0;
            end
            if (gnt !== '0 && prev_gnt === '0) begin
                g = gnt_to_id(gnt);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == g) begin
                        waits[i] = 0;
                    end else if (req[i]) begin
                        waits[i]++;
                        check($sformatf("rnd_starve%0d", i), 32'(waits[i] <= NUM_REQ - 1), 1);
                    end
                end
            end
            prev_gnt = gnt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    if (gnt[i]) begin
                        if (hold[i] == 0) begin
                            req[i]   = 1'b0;
                            waits[i] = 0;
                        end else begin
                            hold[i]--;
                        end
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    req[i]  = 1'b1;
                    hold[i] = int'($urandom_range(0, 12));
                end
            end
        end
        req = '0;
        repeat (20) @(negedge clk);
        check("rnd_end_busy", 32'(busy), 0);
        check("rnd_end_gnt",  32'(gnt),  0);
        check("rnd_end_err",  32'(timeout_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
